shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 83 ++++++++
 tb/tb_shift_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// Multi-cycle shifter: performs one LSL/LSR/ASR/ROR/RRC step per clock
// for a latched amount, with busy during the run and a one-cycle done pulse.
module shift_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] a,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             c_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] M_LSL = 3'd0;
  localparam logic [2:0] M_LSR = 3'd1;
  localparam logic [2:0] M_ASR = 3'd2;
  localparam logic [2:0] M_ROR = 3'd3;
  localparam logic [2:0] M_RRC = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;

  // One single-bit step; result is {carry, value}.
  function automatic logic [WIDTH:0] shift_step(input logic [2:0]       m,
                                                input logic [WIDTH-1:0] v,
                                                input logic             c);
    case (m)
      M_LSL:   shift_step = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      M_LSR:   shift_step = {v[0], 1'b0, v[WIDTH-1:1]};
      M_ASR:   shift_step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      M_ROR:   shift_step = {v[0], v[0], v[WIDTH-1:1]};
      M_RRC:   shift_step = {v[0], c, v[WIDTH-1:1]};
      default: shift_step = {c, v};
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= M_LSL;
      cnt_q   <= '0;
      y       <= '0;
      c_out   <= 1'b0;
    end else begin
      case (state_q)
        S_SHIFT: begin
          {c_out, y} <= shift_step(mode_q, y, c_out);
          cnt_q      <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= S_DONE;
        end
        default: begin
          // IDLE and DONE both accept a new operation; DONE otherwise falls back to IDLE.
          if (start) begin
            y       <= a;
            c_out   <= c_in;
            mode_q  <= mode;
            cnt_q   <= amount;
            state_q <= ((amount != '0) && (mode <= M_RRC)) ? S_SHIFT : S_DONE;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: stimulus pushes expected results, a
// monitor pops and compares on every done pulse.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mode;
  logic [3:0]  amount;
  logic [15:0] a;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] y;
  logic        c_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] y;
    logic        c;
    int          k;
  } exp_t;

  exp_t sb[$];

  shift_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .amount(amount),
    .a(a), .c_in(c_in), .busy(busy), .done(done), .y(y), .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks each done pulse against the queue head.
  initial begin
    int   bcnt;
    exp_t e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bcnt = 0;
      end else begin
        if (busy) bcnt++;
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual y=%0h required no done", y);
          end else begin
            e = sb.pop_front();
            chk("result_y", 32'(y), 32'(e.y));
            chk("result_c", 32'(c_out), 32'(e.c));
            chk("busy_cycles", 32'(bcnt), 32'(e.k));
            chk("busy_low_in_done", 32'(busy), 32'd0);
          end
          bcnt = 0;
        end
      end
    end
  end

  // Called at a negedge; drives start for one cycle, then scrambles the
  // operand inputs so a leak during SHIFT would corrupt the result.
  task automatic issue(input logic [2:0] m, input logic [3:0] k, input logic [15:0] av,
                       input logic ci, input bit push, input logic [15:0] ey,
                       input logic ec, input int ek);
    exp_t e;
    mode = m; amount = k; a = av; c_in = ci; start = 1'b1;
    if (push) begin
      e.y = ey; e.c = ec; e.k = ek;
      sb.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    a      = ~av;
    mode   = m ^ 3'b001;
    amount = ~k;
    c_in   = ~ci;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=pending required=idle within 40 cycles", name);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 3'd0; amount = 4'd0; a = 16'h0; c_in = 1'b0;
    #12;
    chk("reset_y", 32'(y), 32'd0);
    chk("reset_c", 32'(c_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd4, 4'd1, 16'h8001, 1'b0, 1, 16'h4000, 1'b1, 1);
    wait_idle("rrc1");
    issue(3'd2, 4'd4, 16'h8000, 1'b0, 1, 16'hF800, 1'b0, 4);
    wait_idle("asr4");
    issue(3'd1, 4'd4, 16'h8000, 1'b0, 1, 16'h0800, 1'b0, 4);
    wait_idle("lsr4");
    issue(3'd0, 4'd15, 16'h8001, 1'b0, 1, 16'h8000, 1'b0, 15);
    wait_idle("lsl15");
    issue(3'd0, 4'd1, 16'h8001, 1'b0, 1, 16'h0002, 1'b1, 1);
    wait_idle("lsl1");
    repeat (2) @(negedge clk);
    chk("hold_y", 32'(y), 32'h0002);
    chk("hold_c", 32'(c_out), 32'd1);

    // ROR with a start pulse during busy that must be ignored.
    issue(3'd3, 4'd4, 16'h1234, 1'b0, 1, 16'h4123, 1'b0, 4);
    chk("ror_busy", 32'(busy), 32'd1);
    mode = 3'd0; amount = 4'd1; a = 16'hFFFF; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ror4");

    // amount 0 goes straight to DONE, then a back-to-back start in DONE.
    issue(3'd0, 4'd0, 16'hBEEF, 1'b1, 1, 16'hBEEF, 1'b1, 0);
    chk("zero_done_next", 32'(done), 32'd1);
    issue(3'd3, 4'd4, 16'h1234, 1'b0, 1, 16'h4123, 1'b0, 4);
    wait_idle("b2b");

    issue(3'd5, 4'd3, 16'hA5A5, 1'b0, 1, 16'hA5A5, 1'b0, 0);
    wait_idle("reserved");
    issue(3'd4, 4'd2, 16'h0001, 1'b1, 1, 16'hC000, 1'b0, 2);
    wait_idle("rrc2");

    // Reset after three LSR steps aborts without a done pulse.
    issue(3'd1, 4'd8, 16'hFFFF, 1'b0, 0, 16'h0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_y", 32'(y), 32'h1FFF);
    chk("mid_c", 32'(c_out), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_y", 32'(y), 32'd0);
    chk("abort_c", 32'(c_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_abort_busy", 32'(busy), 32'd0);
    chk("post_abort_y", 32'(y), 32'd0);
    issue(3'd1, 4'd8, 16'hFFFF, 1'b0, 1, 16'h00FF, 1'b1, 8);
    wait_idle("lsr8");

    chk("queue_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
